// File: rtl/io_input_debounce_if.sv
// Port bundle for the input debouncer. The stimulus side drives raw_in and ack.
// The debouncer side returns the clean word and its change indicators.
interface io_input_debounce_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] raw_in;
  logic             ack;
  logic [WIDTH-1:0] data_out;
  logic             data_changed;
  logic             change_pending;
  logic [WIDTH-1:0] change_mask;

  modport master (
    output raw_in,
    output ack,
    input  data_out,
    input  data_changed,
    input  change_pending,
    input  change_mask
  );

  modport slave (
    input  raw_in,
    input  ack,
    output data_out,
    output data_changed,
    output change_pending,
    output change_mask
  );
endinterface

// File: rtl/io_input_debounce.sv
// Two-flop synchroniser plus whole-word debouncer feeding external_I1_input.
// A word is committed only after it has been stable for DEBOUNCE_CYCLES clocks.
module io_input_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic               DB_clock,
  input  logic               DB_reset,
  io_input_debounce_if.slave db_if
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] change_mask_q, change_mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_changed_q, data_changed_d;
  logic             change_pending_q, change_pending_d;
  logic             commit_s;

  // Next-state logic: synchroniser shift, debounce window and change flags
  always_comb begin
    sync1_d        = db_if.raw_in;
    sync2_d        = sync1_q;
    cand_d         = cand_q;
    cnt_d          = cnt_q;
    data_out_d     = data_out_q;
    change_mask_d  = change_mask_q;
    data_changed_d = 1'b0;
    commit_s       = 1'b0;

    if (sync2_q != cand_q) begin
      // Any bit moving restarts the window for the whole word.
      cand_d = sync2_q;
      cnt_d  = CNT_ZERO;
    end else if (cand_q != data_out_q) begin
      if (cnt_q == CNT_LAST) begin
        commit_s       = 1'b1;
        data_out_d     = cand_q;
        change_mask_d  = cand_q ^ data_out_q;
        data_changed_d = 1'b1;
        cnt_d          = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end

    // A commit on the same edge as ack keeps the flag set.
    if (commit_s) begin
      change_pending_d = 1'b1;
    end else if (db_if.ack) begin
      change_pending_d = 1'b0;
    end else begin
      change_pending_d = change_pending_q;
    end
  end

  // State registers, cleared asynchronously by DB_reset
  always_ff @(posedge DB_clock or negedge DB_reset) begin
    if (!DB_reset) begin
      sync1_q          <= WORD_ZERO;
      sync2_q          <= WORD_ZERO;
      cand_q           <= WORD_ZERO;
      cnt_q            <= CNT_ZERO;
      data_out_q       <= WORD_ZERO;
      change_mask_q    <= WORD_ZERO;
      data_changed_q   <= 1'b0;
      change_pending_q <= 1'b0;
    end else begin
      sync1_q          <= sync1_d;
      sync2_q          <= sync2_d;
      cand_q           <= cand_d;
      cnt_q            <= cnt_d;
      data_out_q       <= data_out_d;
      change_mask_q    <= change_mask_d;
      data_changed_q   <= data_changed_d;
      change_pending_q <= change_pending_d;
    end
  end

  assign db_if.data_out       = data_out_q;
  assign db_if.change_mask    = change_mask_q;
  assign db_if.data_changed   = data_changed_q;
  assign db_if.change_pending = change_pending_q;

endmodule

// File: tb/tb_io_input_debounce.sv
// Scoreboard bench for io_input_debounce: stimulus queues expected commits,
// per-instance monitors pop and compare on every data_changed pulse.
module tb_io_input_debounce;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   edge_cnt;

  typedef struct {
    logic [15:0] data;
    logic [15:0] mask;
    int          edge_n;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea;
  exp_t        eb;
  logic [15:0] exp_a;
  logic [15:0] exp_b;

  io_input_debounce_if #(.WIDTH(16)) ifa ();
  io_input_debounce_if #(.WIDTH(16)) ifb ();

  io_input_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut_a (
    .DB_clock (clk),
    .DB_reset (rst_n),
    .db_if    (ifa.slave)
  );

  io_input_debounce #(.WIDTH(16), .DEBOUNCE_CYCLES(1), .CNT_W(8)) dut_b (
    .DB_clock (clk),
    .DB_reset (rst_n),
    .db_if    (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, req, edge_cnt);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_a(input logic [15:0] v, input int lat);
    qa.push_back('{data: v, mask: v ^ exp_a, edge_n: edge_cnt + lat});
    exp_a = v;
  endtask

  task automatic expect_b(input logic [15:0] v, input int lat);
    qb.push_back('{data: v, mask: v ^ exp_b, edge_n: edge_cnt + lat});
    exp_b = v;
  endtask

  // Monitor for the DEBOUNCE_CYCLES=4 instance
  always @(negedge clk) begin
    if (rst_n && ifa.data_changed) begin
      if (qa.size() == 0) begin
        check("a_unexpected_commit", {16'h0000, ifa.data_out}, 32'hFFFF_FFFF);
      end else begin
        ea = qa.pop_front();
        check("a_data_out", {16'h0000, ifa.data_out}, {16'h0000, ea.data});
        check("a_change_mask", {16'h0000, ifa.change_mask}, {16'h0000, ea.mask});
        check("a_commit_edge", edge_cnt, ea.edge_n);
        check("a_pending_on_commit", {31'd0, ifa.change_pending}, 32'd1);
      end
    end
  end

  // Monitor for the DEBOUNCE_CYCLES=1 instance
  always @(negedge clk) begin
    if (rst_n && ifb.data_changed) begin
      if (qb.size() == 0) begin
        check("b_unexpected_commit", {16'h0000, ifb.data_out}, 32'hFFFF_FFFF);
      end else begin
        eb = qb.pop_front();
        check("b_data_out", {16'h0000, ifb.data_out}, {16'h0000, eb.data});
        check("b_change_mask", {16'h0000, ifb.change_mask}, {16'h0000, eb.mask});
        check("b_commit_edge", edge_cnt, eb.edge_n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    exp_a      = 16'h0000;
    exp_b      = 16'h0000;
    rst_n      = 1'b0;
    ifa.raw_in = 16'hFFFF;
    ifa.ack    = 1'b0;
    ifb.raw_in = 16'h0000;
    ifb.ack    = 1'b0;

    // Reset holds everything at zero even with raw input high
    cycles(3);
    check("rst_data_out", {16'h0000, ifa.data_out}, 32'h0);
    check("rst_change_mask", {16'h0000, ifa.change_mask}, 32'h0);
    check("rst_data_changed", {31'd0, ifa.data_changed}, 32'd0);
    check("rst_change_pending", {31'd0, ifa.change_pending}, 32'd0);
    rst_n = 1'b1;
    expect_a(16'hFFFF, 7);
    cycles(8);
    check("after_commit_pulse_low", {31'd0, ifa.data_changed}, 32'd0);
    check("after_commit_pending", {31'd0, ifa.change_pending}, 32'd1);
    ifa.ack = 1'b1;
    cycles(1);
    ifa.ack = 1'b0;
    check("ack_clears_pending", {31'd0, ifa.change_pending}, 32'd0);

    // Glitch rejection around a committed 00A5
    ifa.raw_in = 16'h00A5;
    expect_a(16'h00A5, 7);
    cycles(9);
    ifa.raw_in = 16'h00A7;
    cycles(3);
    ifa.raw_in = 16'h00A5;
    cycles(10);
    check("glitch_data_out", {16'h0000, ifa.data_out}, 32'h0000_00A5);
    check("glitch_mask_held", {16'h0000, ifa.change_mask}, 32'h0000_FF5A);
    check("glitch_pending", {31'd0, ifa.change_pending}, 32'd1);

    // Mid-window restart from a 0000 base
    ifa.raw_in = 16'h0000;
    expect_a(16'h0000, 7);
    cycles(9);
    ifa.raw_in = 16'h0001;
    cycles(4);
    ifa.raw_in = 16'h0003;
    expect_a(16'h0003, 7);
    cycles(9);
    check("restart_data_out", {16'h0000, ifa.data_out}, 32'h0000_0003);

    // Ack on the commit edge: set wins; ack on the next idle cycle clears
    check("collision_pending_before", {31'd0, ifa.change_pending}, 32'd1);
    ifa.raw_in = 16'h0000;
    expect_a(16'h0000, 7);
    cycles(6);
    ifa.ack = 1'b1;
    cycles(1);
    check("collision_pending_kept", {31'd0, ifa.change_pending}, 32'd1);
    cycles(1);
    ifa.ack = 1'b0;
    check("idle_ack_clears", {31'd0, ifa.change_pending}, 32'd0);

    // Async reset mid-window discards the candidate
    ifa.raw_in = 16'h5A5A;
    expect_a(16'h5A5A, 7);
    cycles(9);
    ifa.raw_in = 16'h1234;
    cycles(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data_out", {16'h0000, ifa.data_out}, 32'h0);
    check("async_rst_mask", {16'h0000, ifa.change_mask}, 32'h0);
    check("async_rst_pending", {31'd0, ifa.change_pending}, 32'd0);
    check("async_rst_changed", {31'd0, ifa.data_changed}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
    exp_a = 16'h0000;
    expect_a(16'h1234, 7);
    cycles(9);

    // DEBOUNCE_CYCLES=1 instance commits at edge 4
    ifb.raw_in = 16'h8000;
    expect_b(16'h8000, 4);
    cycles(6);
    check("b_data_out_final", {16'h0000, ifb.data_out}, 32'h0000_8000);

    cycles(4);
    check("a_queue_drained", qa.size(), 32'd0);
    check("b_queue_drained", qb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_debounce.md
Name: io_input_debounce

Overview:
- Upstream conditioning stage for the I1 input register. Feeds its external_I1_input.
- Takes raw 16-bit asynchronous external inputs (switches/pins) and synchronises them into the clock domain with two flops.
- Debounces the whole word: a new value is committed only after it has been stable for DEBOUNCE_CYCLES clocks.
- Presents the clean word plus a change pulse, a sticky change flag with acknowledge, and a mask of which bits changed.

Parameters:
- WIDTH, 16, width of the raw input word and of data_out.
- DEBOUNCE_CYCLES, 4, number of consecutive stable synchronised cycles required before commit. Legal range 1..2^CNT_W.
- CNT_W, 8, width of the stability counter.

Ports:
- DB_clock  input  1  single clock; all logic on its rising edge.
- DB_reset  input  1  asynchronous, active-low reset.
- raw_in  input  WIDTH  unsynchronised external inputs.
- ack  input  1  clears change_pending.
- data_out  output  WIDTH  debounced word; drives external_I1_input of the I1 input register.
- data_changed  output  1  one-cycle pulse on each commit.
- change_pending  output  1  sticky: set on commit, cleared by ack.
- change_mask  output  WIDTH  bits that flipped at the most recent commit.

Behaviour:

Reset:
- DB_reset low asynchronously clears sync1, sync2, cand, cnt, data_out, change_mask, data_changed and change_pending to 0.
- Release is synchronous to the next DB_clock edge.
- Reset asserted mid-debounce discards the candidate. No commit occurs.

Synchroniser:
- sync1 <= raw_in; sync2 <= sync1.
- No logic reads sync1 other than sync2.

Debounce, evaluated each edge in priority order:
1. sync2 != cand:
   - cand <= sync2, cnt <= 0.
   - No commit.
2. Else cand != data_out and cnt == DEBOUNCE_CYCLES-1 (commit):
   - data_out <= cand.
   - change_mask <= cand XOR data_out.
   - data_changed <= 1.
   - cnt <= 0.
3. Else cand != data_out:
   - cnt <= cnt+1.
4. Else (idle, cand == data_out):
   - cnt holds at 0.

Latency and width rules:
- A raw change present before edge 1 and held steady commits at edge DEBOUNCE_CYCLES+3, i.e. edge 7 at default.
- DEBOUNCE_CYCLES=1 commits at edge 4.
- cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap.
- Whole-word debounce: any bit changing restarts the window for all bits.

data_changed:
- Asserted exactly one cycle per commit. Deasserted otherwise.

change_pending:
- Set on commit. Cleared on a cycle with ack=1 and no commit.
- Commit and ack on the same edge: set wins, and change_pending stays 1.
- ack while already 0 has no effect.

change_mask:
- Holds its value until the next commit.

Boundary conditions:
- Glitch shorter than the stability window: cand returns to equal data_out, so no commit, no pulse, no mask change.
- Glitch to a third value mid-window: the window restarts from cnt=0 with the new candidate.
- Value that returns to the already-committed data_out: no commit.
- Consecutive commits: at most one commit per DEBOUNCE_CYCLES+1 cycles.

Test Plan:
- Reset: hold DB_reset=0 with raw_in=16'hFFFF -> data_out=0, change_mask=0, data_changed=0, change_pending=0. Release; raw_in stays 16'hFFFF -> data_out=16'hFFFF at edge 7, data_changed high that cycle only, change_mask=16'hFFFF, change_pending=1.
- Glitch rejection: data_out=16'h00A5. Set raw_in=16'h00A7 for 3 cycles, then back to 16'h00A5 -> data_out stays 16'h00A5, no data_changed pulse, change_pending unchanged.
- Mid-window restart: raw 16'h0001 for 4 cycles, then 16'h0003 held -> no commit of 16'h0001. 16'h0003 commits 7 edges after the 16'h0003 transition; change_mask=16'h0003 from a 16'h0000 base.
- Ack collision: change_pending=1. Drive ack=1 on the same edge as a new commit -> change_pending remains 1. Ack on the next idle cycle -> change_pending=0 one edge later.
- Async reset mid-debounce: candidate at cnt=2, pull DB_reset low between edges -> all outputs 0 immediately, before the next clock edge. After release the same raw value needs the full 7 edges.
- Parameter DEBOUNCE_CYCLES=1: step 16'h0000 to 16'h8000 -> commit at edge 4, change_mask=16'h8000.
